// File: rtl/mid_buffer_sched_pkg.sv
// mid_buf_pkg: geometry defaults, derived window counts, counter widths and
// the scheduler state encoding shared by the mid-buffer scheduler slice.
package mid_buf_pkg;

    localparam int ROWS_DEF  = 34;
    localparam int COLS_DEF  = 26;
    localparam int WIN_DEF   = 2;
    localparam int WROWS_DEF = ROWS_DEF / WIN_DEF;   // 17 window rows
    localparam int WCOLS_DEF = COLS_DEF / WIN_DEF;   // 13 window columns

    // Counter width for a range of n values; never collapses to zero bits.
    function automatic int cnt_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    localparam int ROW_W  = cnt_w(ROWS_DEF);   // 6
    localparam int COL_W  = cnt_w(COLS_DEF);   // 5
    localparam int WROW_W = cnt_w(WROWS_DEF);  // 5
    localparam int WCOL_W = cnt_w(WCOLS_DEF);  // 4

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } sched_state_t;

endpackage

// File: rtl/mid_buffer_sched_if.sv
// mid_buffer_sched_if: pixel write side and window read side of the
// mid-buffer scheduler. slave = scheduler, master = upstream/downstream.
interface mid_buffer_sched_if;

    logic                          valid_in;
    logic                          in_ready;
    logic                          wr_en;
    logic [mid_buf_pkg::ROW_W-1:0] wr_row;
    logic [mid_buf_pkg::COL_W-1:0] wr_col;
    logic                          rd_valid;
    logic                          rd_ready;
    logic [mid_buf_pkg::ROW_W-1:0] rd_row_base;
    logic [mid_buf_pkg::COL_W-1:0] rd_col_base;
    logic                          win_last;
    logic                          frame_done;

    modport slave (
        input  valid_in, rd_ready,
        output in_ready, wr_en, wr_row, wr_col,
               rd_valid, rd_row_base, rd_col_base, win_last, frame_done
    );

    modport master (
        output valid_in, rd_ready,
        input  in_ready, wr_en, wr_row, wr_col,
               rd_valid, rd_row_base, rd_col_base, win_last, frame_done
    );

endinterface

// File: rtl/mid_buffer_sched_raster_cnt.sv
// raster_cnt: row/column raster counter. Advances on en, wraps the column at
// COLS-1 into the next row, wraps to (0,0) after the last position. clr wins.
module raster_cnt #(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    parameter int RW   = 1,
    parameter int CW   = 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          en,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic row_end;
    logic col_end;

    assign col_end = (col == CW'(COLS - 1));
    assign row_end = (row == RW'(ROWS - 1));
    assign last    = row_end & col_end;

    // Raster advance; the final position rolls back to the origin.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row <= '0;
            col <= '0;
        end else if (clr) begin
            row <= '0;
            col <= '0;
        end else if (en) begin
            if (col_end) begin
                col <= '0;
                row <= row_end ? '0 : row + 1'b1;
            end else begin
                col <= col + 1'b1;
            end
        end
    end

endmodule

// File: rtl/mid_buffer_sched.sv
// mid_buffer_sched: fills the 32-channel mid buffer one pixel at a time in
// raster order, then walks WINxWIN windows toward the pooling stage.
// Optional feature macro: MID_SCHED_OVF_DET_EN adds a sticky ovf_err output
// flagging valid_in while the scheduler is not accepting pixels.
module mid_buffer_sched
    import mid_buf_pkg::*;
#(
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int WIN  = WIN_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    mid_buffer_sched_if.slave   bus,
    output logic [1:0]          state
`ifdef MID_SCHED_OVF_DET_EN
    ,
    output logic                ovf_err
`endif
);

    localparam int WROWS = ROWS / WIN;
    localparam int WCOLS = COLS / WIN;
    localparam int WRW   = cnt_w(WROWS);
    localparam int WCW   = cnt_w(WCOLS);

    // Geometry must tile exactly into windows and fit the coordinate ports.
    if ((ROWS % WIN) != 0 || (COLS % WIN) != 0) begin : g_bad_tiling
        $error("mid_buffer_sched: ROWS/COLS must be multiples of WIN");
    end
    if (ROWS > (1 << ROW_W) || COLS > (1 << COL_W)) begin : g_bad_size
        $error("mid_buffer_sched: ROWS/COLS exceed coordinate width");
    end

    sched_state_t     state_q;
    logic             rdy_q;
    logic             rd_valid_q;
    logic             done_q;
    logic             fill_last;
    logic             win_last_c;
    logic             rd_fire;
    logic [WRW-1:0]   win_row;
    logic [WCW-1:0]   win_col;

    assign bus.in_ready   = rdy_q;
    assign bus.wr_en      = bus.valid_in & rdy_q;
    assign bus.rd_valid   = rd_valid_q;
    assign bus.frame_done = done_q;
    assign bus.win_last   = win_last_c & (state_q == DRAIN);
    assign rd_fire        = rd_valid_q & bus.rd_ready;
    assign state          = state_q;

    // Window bases are a fixed scaling of the registered window index.
    assign bus.rd_row_base = ROW_W'(int'(win_row) * WIN);
    assign bus.rd_col_base = COL_W'(int'(win_col) * WIN);

    // Buffer write coordinate; a flushed write is not counted.
    raster_cnt #(.ROWS(ROWS), .COLS(COLS), .RW(ROW_W), .CW(COL_W)) u_fill_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .en   (bus.wr_en & ~flush),
        .row  (bus.wr_row),
        .col  (bus.wr_col),
        .last (fill_last)
    );

    // Window index; only a completed handshake advances it.
    raster_cnt #(.ROWS(WROWS), .COLS(WCOLS), .RW(WRW), .CW(WCW)) u_win_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (flush),
        .en   (rd_fire & ~flush),
        .row  (win_row),
        .col  (win_col),
        .last (win_last_c)
    );

    // Frame sequencing with registered handshake flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b1;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else if (flush) begin
            state_q    <= IDLE;
            rdy_q      <= 1'b1;
            rd_valid_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            case (state_q)
                IDLE, FILL: begin
                    if (bus.wr_en) begin
                        if (fill_last) begin
                            state_q    <= DRAIN;
                            rdy_q      <= 1'b0;
                            rd_valid_q <= 1'b1;
                        end else begin
                            state_q <= FILL;
                        end
                    end
                end
                DRAIN: begin
                    if (rd_fire && win_last_c) begin
                        state_q    <= DONE;
                        rd_valid_q <= 1'b0;
                        done_q     <= 1'b1;
                    end
                end
                DONE: begin
                    state_q <= IDLE;
                    rdy_q   <= 1'b1;
                    done_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    rdy_q      <= 1'b1;
                    rd_valid_q <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

`ifdef MID_SCHED_OVF_DET_EN
    // Sticky flag: upstream offered a pixel the scheduler could not take.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            ovf_err <= 1'b0;
        else if (flush)
            ovf_err <= 1'b0;
        else if (bus.valid_in && !rdy_q)
            ovf_err <= 1'b1;
    end
`endif

endmodule

// File: tb/tb_mid_buffer_sched.sv
// tb_mid_buffer_sched: directed frames with a queue scoreboard. The stimulus
// process pushes expected writes/windows/frame_done; a negedge monitor pops
// and compares whenever the DUT presents one.
module tb_mid_buffer_sched;

    localparam int R  = 34;
    localparam int C  = 26;
    localparam int W  = 2;
    localparam int WR = R / W;   // 17
    localparam int WC = C / W;   // 13

    typedef struct packed {
        logic [5:0] r;
        logic [4:0] c;
    } wr_t;

    typedef struct packed {
        logic [5:0] r;
        logic [4:0] c;
        logic       last;
    } win_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       flush = 1'b0;
    logic [1:0] state;
`ifdef MID_SCHED_OVF_DET_EN
    logic       ovf_err;
`endif

    mid_buffer_sched_if mif();

    mid_buffer_sched #(.ROWS(R), .COLS(C), .WIN(W)) dut (
        .clk   (clk),
        .rst   (rst),
        .flush (flush),
        .bus   (mif.slave),
        .state (state)
`ifdef MID_SCHED_OVF_DET_EN
        ,
        .ovf_err (ovf_err)
`endif
    );

    always #5 clk = ~clk;

    int   n_checks = 0;
    int   n_errors = 0;
    wr_t  wr_q[$];
    win_t win_q[$];
    bit   done_q[$];
    int   done_cnt = 0;
    int   win_idx = 0;
    bit   stall_prev = 0;
    win_t prev_win;
    wr_t  e_wr;
    win_t e_win;
    bit   e_done;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor, sampling away from the rising edge.
    always @(negedge clk) begin
        if (rst) begin
            stall_prev = 0;
            win_idx    = 0;
        end else begin
            if (mif.wr_en) begin
                if (wr_q.size() == 0) begin
                    chk("wr_unexpected", mif.wr_en, 0);
                end else begin
                    e_wr = wr_q.pop_front();
                    chk("wr_row", mif.wr_row, e_wr.r);
                    chk("wr_col", mif.wr_col, e_wr.c);
                end
            end
            if (stall_prev && mif.rd_valid) begin
                chk("stall_row", mif.rd_row_base, prev_win.r);
                chk("stall_col", mif.rd_col_base, prev_win.c);
                chk("stall_last", mif.win_last, prev_win.last);
            end
            if (mif.rd_valid && mif.rd_ready) begin
                if (win_q.size() == 0) begin
                    chk("win_unexpected", mif.rd_valid, 0);
                end else begin
                    e_win = win_q.pop_front();
                    chk("win_row", mif.rd_row_base, e_win.r);
                    chk("win_col", mif.rd_col_base, e_win.c);
                    chk("win_last", mif.win_last, e_win.last);
                end
                // Hand-computed anchors of the window walk.
                if (win_idx == 0)
                    chk("win0_base", {mif.rd_row_base, mif.rd_col_base}, {6'd0, 5'd0});
                if (win_idx == 13)
                    chk("win13_base", {mif.rd_row_base, mif.rd_col_base}, {6'd2, 5'd0});
                if (win_idx == 220)
                    chk("win220", {mif.rd_row_base, mif.rd_col_base, mif.win_last}, {6'd32, 5'd24, 1'b1});
                win_idx++;
            end
            if (mif.frame_done) begin
                if (done_q.size() == 0) begin
                    chk("frame_done_unexpected", mif.frame_done, 0);
                end else begin
                    e_done = done_q.pop_front();
                    chk("frame_done", mif.frame_done, e_done);
                end
                done_cnt++;
                win_idx = 0;
            end
            stall_prev = mif.rd_valid && !mif.rd_ready;
            prev_win   = '{r: mif.rd_row_base, c: mif.rd_col_base, last: mif.win_last};
        end
    end

    task automatic push_writes(input int n);
        for (int i = 0; i < n; i++)
            wr_q.push_back('{r: 6'(i / C), c: 5'(i % C)});
    endtask

    task automatic push_windows(input int n);
        for (int i = 0; i < n; i++)
            win_q.push_back('{r: 6'((i / WC) * W), c: 5'((i % WC) * W),
                              last: (i == WR * WC - 1)});
    endtask

    // Called at posedge+1; returns at posedge+1 after the n-th acceptance.
    task automatic fill(input int n, input bit gaps);
        int sent = 0;
        bit v;
        while (sent < n) begin
            v = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            mif.valid_in = v;
            @(posedge clk); #1;
            if (v) sent++;
        end
        mif.valid_in = 0;
    endtask

    task automatic drain(input bit rnd);
        int start = done_cnt;
        int cyc = 0;
        while (done_cnt == start && cyc < 3000) begin
            mif.rd_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            @(posedge clk); #1;
            cyc++;
        end
        mif.rd_ready = 0;
        chk("drain_frame_done_count", done_cnt, start + 1);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_state"}, state, 0);
        chk({tag, "_in_ready"}, mif.in_ready, 1);
        chk({tag, "_rd_valid"}, mif.rd_valid, 0);
        chk({tag, "_win_last"}, mif.win_last, 0);
        chk({tag, "_frame_done"}, mif.frame_done, 0);
        chk({tag, "_wr_pos"}, {mif.wr_row, mif.wr_col}, 0);
        chk({tag, "_rd_base"}, {mif.rd_row_base, mif.rd_col_base}, 0);
    endtask

    initial begin
        int d0;
        mif.valid_in = 0;
        mif.rd_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        chk_reset_vals("in_reset");
        rst = 0;
        @(posedge clk); #1;
        chk_reset_vals("post_reset");

        // Frame 1: back-to-back pixels, downstream always ready.
        push_writes(884);
        fill(884, 0);
        chk("f1_state_drain", state, 2);
        chk("f1_wr_cleared", {mif.wr_row, mif.wr_col}, 0);
        push_windows(221);
        done_q.push_back(1);
        drain(0);
        chk("f1_state_idle", state, 0);

        // Frame 2: gappy fill, random downstream stalls.
        push_writes(884);
        fill(884, 1);
        chk("f2_state_drain", state, 2);
        push_windows(221);
        done_q.push_back(1);
        drain(1);
        chk("f2_state_idle", state, 0);

        // Flush on pixel 500: the write strobe shows (19,5) but is discarded.
        d0 = done_cnt;
        push_writes(500);
        fill(499, 0);
        mif.valid_in = 1;
        flush = 1;
        @(posedge clk); #1;
        mif.valid_in = 0;
        flush = 0;
        chk("flush_state_idle", state, 0);
        chk("flush_wr_pos", {mif.wr_row, mif.wr_col}, 0);
        repeat (3) @(posedge clk);
        #1;
        chk("flush_no_frame_done", done_cnt, d0);

        // Frame 3 from origin, reset during window 100.
        push_writes(884);
        fill(884, 0);
        chk("f3_state_drain", state, 2);
        push_windows(100);
        for (int i = 0; i < 100; i++) begin
            mif.rd_ready = 1;
            @(posedge clk); #1;
        end
        mif.rd_ready = 0;
        chk("win100_base", {mif.rd_row_base, mif.rd_col_base}, {6'd14, 5'd18});
`ifdef MID_SCHED_OVF_DET_EN
        chk("ovf_clear_before", ovf_err, 0);
        mif.valid_in = 1;
        @(posedge clk); #1;
        mif.valid_in = 0;
        chk("ovf_set", ovf_err, 1);
        repeat (3) @(posedge clk);
        #1;
        chk("ovf_sticky", ovf_err, 1);
`endif
        #2 rst = 1;
        #1;
        chk_reset_vals("async_reset");
`ifdef MID_SCHED_OVF_DET_EN
        chk("ovf_reset", ovf_err, 0);
`endif
        @(posedge clk); #1;
        rst = 0;
        repeat (5) @(posedge clk);
        #1;
        chk("after_rst_idle", state, 0);
        chk("after_rst_no_frame_done", done_cnt, d0);

        chk("wr_q_empty", wr_q.size(), 0);
        chk("win_q_empty", win_q.size(), 0);
        chk("done_q_empty", done_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
